// File: rtl/emissor_requisicoes.sv
// Request issuer for the two-institution priority controller.
// Holds one request per channel, presents snapshots and retires/retries.
module emissor_requisicoes #(
    parameter int MAX_PERDAS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in1_valid,
    input  logic [2:0]  in1_perfil,
    input  logic [2:0]  in1_func,
    output logic        in1_ready,
    input  logic        in2_valid,
    input  logic [2:0]  in2_perfil,
    input  logic [2:0]  in2_func,
    output logic        in2_ready,
    output logic [11:0] req_bus,
    output logic        req_valid,
    input  logic [11:0] grant_in,
    output logic        done1,
    output logic        done2,
    output logic        erro1,
    output logic        erro2,
    output logic [2:0]  done1_func,
    output logic [2:0]  done2_func
);

    localparam int PW = $clog2(MAX_PERDAS + 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PERDAS);

    typedef enum logic [1:0] {OCIOSO, APRESENTA, ENTREGA} estado_t;

    estado_t estado;

    logic [1:0] valid_v, full, inv, acc, part, masked;
    logic [1:0] cf, cinv, mask, ret, lost;
    logic [1:0] done_r, erro_r;
    logic [2:0] perfil_v [2];
    logic [2:0] func_v [2];
    logic [2:0] perfil_h [2];
    logic [2:0] func_h [2];
    logic [2:0] dfunc [2];
    logic [5:0] cslot [2];
    logic [5:0] snap [2];
    logic [5:0] pslot [2];
    logic [5:0] gslot [2];
    logic [PW-1:0] perdas [2];

    function automatic logic invalido(input logic [2:0] p, input logic [2:0] f);
        return !(p == 3'b001 || p == 3'b010 || p == 3'b100) || f == 3'b000;
    endfunction

    assign valid_v = {in2_valid, in1_valid};
    assign perfil_v[0] = in1_perfil;
    assign perfil_v[1] = in2_perfil;
    assign func_v[0] = in1_func;
    assign func_v[1] = in2_func;

    assign in1_ready = ~full[0];
    assign in2_ready = ~full[1];

    assign pslot[0] = req_bus[5:0];
    assign pslot[1] = req_bus[11:6];
    assign gslot[0] = grant_in[5:0];
    assign gslot[1] = grant_in[11:6];

    assign done1 = done_r[0];
    assign done2 = done_r[1];
    assign erro1 = erro_r[0];
    assign erro2 = erro_r[1];
    assign done1_func = dfunc[0];
    assign done2_func = dfunc[1];

    // A holder refilled while the previous result is delivered joins the
    // snapshot taken at that same edge, so a contender never skips a round.
    always_comb begin
        acc = '0;
        cf = '0;
        cinv = '0;
        mask = '0;
        ret = '0;
        lost = '0;
        for (int k = 0; k < 2; k++) begin
            cslot[k] = '0;
            snap[k] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            acc[k] = valid_v[k] & ~full[k];
            if (full[k]) begin
                cf[k] = 1'b1;
                cinv[k] = inv[k];
                cslot[k] = {func_h[k], perfil_h[k]};
            end else begin
                cf[k] = acc[k] & (estado == ENTREGA);
                cinv[k] = invalido(perfil_v[k], func_v[k]);
                cslot[k] = {func_v[k], perfil_v[k]};
            end
        end
        mask[1] = (perdas[0] == PMAX) & cf[1];
        mask[0] = (perdas[1] == PMAX) & cf[0] & ~mask[1];
        for (int k = 0; k < 2; k++) begin
            if (cf[k] & ~cinv[k] & ~mask[k])
                snap[k] = cslot[k];
            if (estado == APRESENTA && part[k]) begin
                if (inv[k])
                    ret[k] = 1'b1;
                else if (!masked[k] && gslot[k] == pslot[k])
                    ret[k] = 1'b1;
                else if (!masked[k])
                    lost[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
            full <= '0;
            inv <= '0;
            part <= '0;
            masked <= '0;
            req_bus <= '0;
            req_valid <= 1'b0;
            done_r <= '0;
            erro_r <= '0;
            for (int k = 0; k < 2; k++) begin
                perfil_h[k] <= '0;
                func_h[k] <= '0;
                dfunc[k] <= '0;
                perdas[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) begin
                    full[k] <= 1'b1;
                    perfil_h[k] <= perfil_v[k];
                    func_h[k] <= func_v[k];
                    inv[k] <= invalido(perfil_v[k], func_v[k]);
                end else if (ret[k]) begin
                    full[k] <= 1'b0;
                end
                done_r[k] <= ret[k];
                erro_r[k] <= ret[k] & inv[k];
                dfunc[k] <= (ret[k] & ~inv[k]) ? gslot[k][5:3] : 3'b000;
                if (ret[k])
                    perdas[k] <= '0;
                else if (lost[k] && perdas[k] != PMAX)
                    perdas[k] <= perdas[k] + 1'b1;
            end
            unique case (estado)
                OCIOSO: begin
                    if (|full) begin
                        estado <= APRESENTA;
                        req_bus <= {snap[1], snap[0]};
                        req_valid <= 1'b1;
                        part <= cf;
                        masked <= mask;
                    end
                end
                APRESENTA: begin
                    estado <= ENTREGA;
                    req_bus <= '0;
                    req_valid <= 1'b0;
                end
                ENTREGA: begin
                    if (|cf) begin
                        estado <= APRESENTA;
                        req_bus <= {snap[1], snap[0]};
                        req_valid <= 1'b1;
                        part <= cf;
                        masked <= mask;
                    end else begin
                        estado <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_emissor_requisicoes.sv
// Directed bench for emissor_requisicoes with a small controller model.
module tb_emissor_requisicoes;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in1_valid = 1'b0;
    logic [2:0]  in1_perfil = '0;
    logic [2:0]  in1_func = '0;
    logic        in1_ready;
    logic        in2_valid = 1'b0;
    logic [2:0]  in2_perfil = '0;
    logic [2:0]  in2_func = '0;
    logic        in2_ready;
    logic [11:0] req_bus;
    logic        req_valid;
    logic [11:0] grant_in;
    logic        done1, done2, erro1, erro2;
    logic [2:0]  done1_func, done2_func;

    int n_checks = 0;
    int n_fail = 0;

    // Controller model: disjoint funcs both granted, overlap goes to IE02.
    logic overlap;
    assign overlap = |(req_bus[5:3] & req_bus[11:9]);
    assign grant_in = !req_valid ? 12'h000 :
                      overlap ? {req_bus[11:6], 6'b000000} : req_bus;

    emissor_requisicoes #(.MAX_PERDAS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_valid(in1_valid), .in1_perfil(in1_perfil),
        .in1_func(in1_func), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_perfil(in2_perfil),
        .in2_func(in2_func), .in2_ready(in2_ready),
        .req_bus(req_bus), .req_valid(req_valid), .grant_in(grant_in),
        .done1(done1), .done2(done2), .erro1(erro1), .erro2(erro2),
        .done1_func(done1_func), .done2_func(done2_func)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({in1_ready, in2_ready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 11", {in1_ready, in2_ready});
        end
        n_checks++;
        if ({req_valid, req_bus} !== 13'h0) begin
            n_fail++; $display("FAIL reset_bus: got %b/%h expected 0/000", req_valid, req_bus);
        end
        n_checks++;
        if ({done1, done2, erro1, erro2, done1_func, done2_func} !== 10'h0) begin
            n_fail++; $display("FAIL reset_done: got %b%b%b%b expected 0000", done1, done2, erro1, erro2);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        in1_valid = 1'b1; in1_perfil = 3'b001; in1_func = 3'b011;
        tick();
        in1_valid = 1'b0;
        n_checks++;
        if ({in1_ready, req_valid} !== 2'b00) begin
            n_fail++; $display("FAIL single_accept: got ready/valid %b%b expected 00", in1_ready, req_valid);
        end
        tick();
        n_checks++;
        if ({req_valid, req_bus} !== {1'b1, 12'h019}) begin
            n_fail++; $display("FAIL single_bus: got %b/%h expected 1/019", req_valid, req_bus);
        end
        tick();
        n_checks++;
        if ({done1, erro1, done1_func, done2} !== {1'b1, 1'b0, 3'b011, 1'b0}) begin
            n_fail++; $display("FAIL single_done: got d1=%b e1=%b f1=%b d2=%b expected 1 0 011 0", done1, erro1, done1_func, done2);
        end
        n_checks++;
        if ({req_valid, req_bus, in1_ready} !== {1'b0, 12'h000, 1'b1}) begin
            n_fail++; $display("FAIL single_entrega: got %b/%h ready %b expected 0/000 ready 1", req_valid, req_bus, in1_ready);
        end
        tick();
        n_checks++;
        if ({done1, done1_func} !== 4'b0) begin
            n_fail++; $display("FAIL single_pulse: got %b/%b expected 0/000", done1, done1_func);
        end
    endtask

    task automatic test_back_to_back;
        in1_valid = 1'b1; in1_perfil = 3'b100; in1_func = 3'b010;
        tick();
        in1_valid = 1'b0;
        tick();
        tick();
        in1_valid = 1'b1; in1_perfil = 3'b010; in1_func = 3'b001;
        tick();
        in1_valid = 1'b0;
        n_checks++;
        if ({req_valid, req_bus} !== {1'b1, 12'h00A}) begin
            n_fail++; $display("FAIL b2b_bus: got %b/%h expected 1/00a", req_valid, req_bus);
        end
        tick();
        n_checks++;
        if ({done1, done1_func} !== {1'b1, 3'b001}) begin
            n_fail++; $display("FAIL b2b_done: got %b/%b expected 1/001", done1, done1_func);
        end
        tick();
    endtask

    task automatic test_diff_func;
        in1_valid = 1'b1; in1_perfil = 3'b001; in1_func = 3'b001;
        in2_valid = 1'b1; in2_perfil = 3'b010; in2_func = 3'b110;
        tick();
        in1_valid = 1'b0; in2_valid = 1'b0;
        tick();
        n_checks++;
        if ({req_valid, req_bus} !== {1'b1, 12'hC89}) begin
            n_fail++; $display("FAIL diff_bus: got %b/%h expected 1/c89", req_valid, req_bus);
        end
        tick();
        n_checks++;
        if ({done1, done1_func, done2, done2_func} !== {1'b1, 3'b001, 1'b1, 3'b110}) begin
            n_fail++; $display("FAIL diff_done: got %b/%b %b/%b expected 1/001 1/110", done1, done1_func, done2, done2_func);
        end
        tick();
    endtask

    task automatic test_equal_func;
        in1_valid = 1'b1; in1_perfil = 3'b001; in1_func = 3'b100;
        in2_valid = 1'b1; in2_perfil = 3'b100; in2_func = 3'b100;
        tick();
        in1_valid = 1'b0; in2_valid = 1'b0;
        tick();
        n_checks++;
        if (req_bus !== 12'h921) begin
            n_fail++; $display("FAIL equal_bus: got %h expected 921", req_bus);
        end
        tick();
        n_checks++;
        if ({done1, done2, done2_func} !== {1'b0, 1'b1, 3'b100}) begin
            n_fail++; $display("FAIL equal_done: got d1=%b d2=%b f2=%b expected 0 1 100", done1, done2, done2_func);
        end
        tick();
        n_checks++;
        if ({req_valid, req_bus} !== {1'b1, 12'h021}) begin
            n_fail++; $display("FAIL equal_retry_bus: got %b/%h expected 1/021", req_valid, req_bus);
        end
        tick();
        n_checks++;
        if ({done1, done1_func, done2} !== {1'b1, 3'b100, 1'b0}) begin
            n_fail++; $display("FAIL equal_retry_done: got %b/%b d2=%b expected 1/100 0", done1, done1_func, done2);
        end
        tick();
    endtask

    task automatic test_starvation;
        in1_valid = 1'b1; in1_perfil = 3'b001; in1_func = 3'b100;
        in2_valid = 1'b1; in2_perfil = 3'b010; in2_func = 3'b100;
        tick();
        in1_valid = 1'b0; in2_valid = 1'b0;
        tick();
        for (int r = 1; r <= 4; r++) begin
            n_checks++;
            if (req_bus !== ((r < 4) ? 12'h8A1 : 12'h021)) begin
                n_fail++; $display("FAIL starve_bus_r%0d: got %h expected %h", r, req_bus, (r < 4) ? 12'h8A1 : 12'h021);
            end
            tick();
            n_checks++;
            if (r < 4 && {done1, done2} !== 2'b01) begin
                n_fail++; $display("FAIL starve_lose_r%0d: got d1d2=%b expected 01", r, {done1, done2});
            end else if (r == 4 && {done1, done1_func, done2} !== {1'b1, 3'b100, 1'b0}) begin
                n_fail++; $display("FAIL starve_forced: got %b/%b d2=%b expected 1/100 0", done1, done1_func, done2);
            end
            if (r < 4) begin
                in2_valid = 1'b1;
                tick();
                in2_valid = 1'b0;
            end else begin
                tick();
            end
        end
        n_checks++;
        if ({req_valid, req_bus} !== {1'b1, 12'h880}) begin
            n_fail++; $display("FAIL starve_after_bus: got %b/%h expected 1/880", req_valid, req_bus);
        end
        tick();
        n_checks++;
        if ({done1, done2, done2_func} !== {1'b0, 1'b1, 3'b100}) begin
            n_fail++; $display("FAIL starve_after_done: got d1=%b d2=%b f2=%b expected 0 1 100", done1, done2, done2_func);
        end
        tick();
    endtask

    task automatic test_invalid;
        in1_valid = 1'b1; in1_perfil = 3'b011; in1_func = 3'b001;
        tick();
        in1_valid = 1'b0;
        tick();
        n_checks++;
        if ({req_valid, req_bus} !== {1'b1, 12'h000}) begin
            n_fail++; $display("FAIL invalid_bus: got %b/%h expected 1/000", req_valid, req_bus);
        end
        tick();
        n_checks++;
        if ({done1, erro1, done1_func} !== {1'b1, 1'b1, 3'b000}) begin
            n_fail++; $display("FAIL invalid_done: got d=%b e=%b f=%b expected 1 1 000", done1, erro1, done1_func);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        in1_valid = 1'b1; in1_perfil = 3'b100; in1_func = 3'b010;
        tick();
        in1_valid = 1'b0;
        tick();
        n_checks++;
        if (req_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got req_valid %b expected 1", req_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_valid, req_bus, in1_ready, in2_ready} !== {1'b0, 12'h000, 2'b11}) begin
            n_fail++; $display("FAIL midrst_now: got %b/%h ready %b%b expected 0/000 11", req_valid, req_bus, in1_ready, in2_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({done1, done2, req_valid} !== 3'b000) begin
                n_fail++; $display("FAIL midrst_quiet_c%0d: got d1 d2 v=%b%b%b expected 000", c, done1, done2, req_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_diff_func();
        test_equal_func();
        test_starvation();
        test_invalid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
